// File: rtl/ram_loader.sv
// Streams a RAM address range into either the pixel store, one word per write,
// or the weight store, packing pack_len words MSB-first into each weight word.
module ram_loader #(
    parameter int unsigned DW     = 8,
    parameter int unsigned K      = 9,
    parameter int unsigned RAM_AW = 13,
    parameter int unsigned PAW    = 13,
    parameter int unsigned WAW    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              mode,
    input  logic [RAM_AW-1:0] first_addr,
    input  logic [RAM_AW-1:0] last_addr,
    input  logic [3:0]        pack_len,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_re,
    input  logic [DW-1:0]     ram_rdata,
    output logic              we_p,
    output logic [PAW-1:0]    addrp,
    output logic [DW-1:0]     dp,
    output logic              we_w,
    output logic [WAW-1:0]    addrw,
    output logic [K*DW-1:0]   dw,
    output logic              busy,
    output logic              done
);

    localparam int unsigned WW = K * DW;
    localparam int unsigned LW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic              mode_q;
    logic [RAM_AW-1:0] first_q;
    logic [RAM_AW-1:0] span_q;
    logic [LW-1:0]     pl_q;
    logic [RAM_AW-1:0] idx;
    logic [PAW-1:0]    wr_idx;
    logic [WAW-1:0]    grp;
    logic [LW-1:0]     lane;
    logic [WW-1:0]     pack_buf;
    logic              re_d1;
    logic              last_d1;

    logic              empty_c;
    logic              read_last_c;
    logic [LW-1:0]     pl_clamp_c;
    int unsigned       shift_c;
    logic [WW-1:0]     lane_word_c;
    logic [WW-1:0]     merged_c;
    logic              group_full_c;

    // Start-time decode and the lane placement of the returning word
    always_comb begin
        empty_c     = (last_addr < first_addr);
        read_last_c = (idx == span_q);
        if (pack_len == 4'd0) begin
            pl_clamp_c = LW'(1);
        end else if (32'(pack_len) > K) begin
            pl_clamp_c = LW'(K);
        end else begin
            pl_clamp_c = pack_len;
        end
        shift_c      = (K - 1 - 32'(lane)) * DW;
        lane_word_c  = WW'(ram_rdata) << shift_c;
        merged_c     = pack_buf | lane_word_c;
        group_full_c = (lane == (pl_q - LW'(1)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN leaves once the last returning word has been written
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = empty_c ? DRAIN : READ;
            READ:    if (read_last_c) state_next = DRAIN;
            DRAIN:   if (!re_d1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_re   <= 1'b0;
            we_p     <= 1'b0;
            addrp    <= '0;
            dp       <= '0;
            we_w     <= 1'b0;
            addrw    <= '0;
            dw       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mode_q   <= 1'b0;
            first_q  <= '0;
            span_q   <= '0;
            pl_q     <= LW'(1);
            idx      <= '0;
            wr_idx   <= '0;
            grp      <= '0;
            lane     <= '0;
            pack_buf <= '0;
            re_d1    <= 1'b0;
            last_d1  <= 1'b0;
        end else begin
            ram_re  <= 1'b0;
            we_p    <= 1'b0;
            we_w    <= 1'b0;
            re_d1   <= ram_re;
            last_d1 <= ram_re && read_last_c;
            busy    <= (state_next != IDLE);
            done    <= (state_next == DONE);

            case (state)
                IDLE: begin
                    if (go) begin
                        mode_q   <= mode;
                        first_q  <= first_addr;
                        span_q   <= last_addr - first_addr;
                        pl_q     <= pl_clamp_c;
                        idx      <= '0;
                        wr_idx   <= '0;
                        grp      <= '0;
                        lane     <= '0;
                        pack_buf <= '0;
                        if (!empty_c) begin
                            ram_re   <= 1'b1;
                            ram_addr <= first_addr;
                        end
                    end
                end
                READ: begin
                    if (!read_last_c) begin
                        ram_re   <= 1'b1;
                        ram_addr <= first_q + idx + RAM_AW'(1);
                        idx      <= idx + RAM_AW'(1);
                    end
                end
                default: ;
            endcase

            // Returned word: direct pixel write, or lane fill with flush on group end / range end
            if (re_d1) begin
                if (!mode_q) begin
                    we_p   <= 1'b1;
                    addrp  <= wr_idx;
                    dp     <= ram_rdata;
                    wr_idx <= wr_idx + PAW'(1);
                end else if (group_full_c || last_d1) begin
                    we_w     <= 1'b1;
                    addrw    <= grp;
                    dw       <= merged_c;
                    grp      <= grp + WAW'(1);
                    lane     <= '0;
                    pack_buf <= '0;
                end else begin
                    pack_buf <= merged_c;
                    lane     <= lane + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: pixel/weight loads, clamping, empty range,
// ignored go while busy, and mid-load reset with expected values worked by hand.
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        mode;
    logic [12:0] first_addr;
    logic [12:0] last_addr;
    logic [3:0]  pack_len;
    logic [12:0] ram_addr;
    logic        ram_re;
    logic [7:0]  ram_rdata;
    logic        we_p;
    logic [12:0] addrp;
    logic [7:0]  dp;
    logic        we_w;
    logic [10:0] addrw;
    logic [71:0] dw;
    logic        busy;
    logic        done;

    ram_loader dut (
        .clk(clk), .rst_n(rst_n), .go(go), .mode(mode),
        .first_addr(first_addr), .last_addr(last_addr), .pack_len(pack_len),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .we_p(we_p), .addrp(addrp), .dp(dp),
        .we_w(we_w), .addrw(addrw), .dw(dw),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:8191];
    always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int go_cyc = 0;
    int both_hi = 0;

    int          rd_addr[$], rd_cyc[$];
    int          p_addr[$], p_cyc[$];
    logic [7:0]  p_data[$];
    int          w_addr[$], w_cyc[$];
    logic [71:0] w_data[$];
    int          done_cyc[$];

    // Write/read/done log sampled mid-cycle
    always @(negedge clk) begin
        if (ram_re) begin rd_addr.push_back(int'(ram_addr)); rd_cyc.push_back(cyc); end
        if (we_p) begin p_addr.push_back(int'(addrp)); p_data.push_back(dp); p_cyc.push_back(cyc); end
        if (we_w) begin w_addr.push_back(int'(addrw)); w_data.push_back(dw); w_cyc.push_back(cyc); end
        if (done) done_cyc.push_back(cyc);
        if (we_p && we_w) both_hi++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [71:0] put_lane(input logic [71:0] w, input int ln, input logic [7:0] v);
        logic [71:0] r;
        r = w;
        r[(8 - ln) * 8 +: 8] = v;
        return r;
    endfunction

    task automatic clear_log();
        rd_addr.delete(); rd_cyc.delete();
        p_addr.delete(); p_data.delete(); p_cyc.delete();
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic start(input logic m, input int f, input int l, input int pl);
        @(negedge clk);
        clear_log();
        mode = m;
        first_addr = 13'(f);
        last_addr = 13'(l);
        pack_len = 4'(pl);
        go = 1'b1;
        @(posedge clk);
        #1;
        go_cyc = cyc;
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, 128'(seen), 128'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_pixel4(input string tag);
        logic [7:0] exp_d [4];
        exp_d[0] = 8'd5; exp_d[1] = 8'hFD; exp_d[2] = 8'd7; exp_d[3] = 8'd0;
        check({tag, "_nrd"}, 128'(rd_addr.size()), 128'(4));
        check({tag, "_nwp"}, 128'(p_addr.size()), 128'(4));
        check({tag, "_nww"}, 128'(w_addr.size()), 128'(0));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_rdaddr%0d", tag, k), 128'(rd_addr[k]), 128'(100 + k));
            check($sformatf("%s_rdcyc%0d", tag, k), 128'(rd_cyc[k] - go_cyc), 128'(k));
            check($sformatf("%s_paddr%0d", tag, k), 128'(p_addr[k]), 128'(k));
            check($sformatf("%s_pdata%0d", tag, k), 128'(p_data[k]), 128'(exp_d[k]));
            check($sformatf("%s_pcyc%0d", tag, k), 128'(p_cyc[k] - go_cyc), 128'(2 + k));
        end
        check({tag, "_ndone"}, 128'(done_cyc.size()), 128'(1));
        check({tag, "_donecyc"}, 128'(done_cyc[0] - go_cyc), 128'(6));
    endtask

    logic [71:0] e0, e1, e2;
    int np;

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
        mem[100] = 8'd5; mem[101] = 8'hFD; mem[102] = 8'd7; mem[103] = 8'd0;
        for (int k = 0; k < 18; k++) mem[200 + k] = 8'(k + 1);
        for (int k = 0; k < 7; k++) mem[300 + k] = 8'(8'hA1 + k);
        mem[400] = 8'h11; mem[401] = 8'h22;
        for (int k = 0; k < 10; k++) mem[500 + k] = 8'(8'h30 + k);

        rst_n = 1'b0; go = 1'b0; mode = 1'b0;
        first_addr = '0; last_addr = '0; pack_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_re", 128'(ram_re), 128'(0));
        check("rst_we_p", 128'(we_p), 128'(0));
        check("rst_we_w", 128'(we_w), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_ram_addr", 128'(ram_addr), 128'(0));
        check("rst_dw", 128'(dw), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Pixel load of 4 words
        start(1'b0, 100, 103, 0);
        check("pix_busy", 128'(busy), 128'(1));
        wait_done("pix_done_seen");
        check_pixel4("pix");
        check("pix_busy_after", 128'(busy), 128'(0));

        // Two full weight groups of 9 lanes
        start(1'b1, 200, 217, 9);
        wait_done("wfull_done_seen");
        e0 = '0; e1 = '0;
        for (int l = 0; l < 9; l++) begin
            e0 = put_lane(e0, l, 8'(l + 1));
            e1 = put_lane(e1, l, 8'(l + 10));
        end
        check("wfull_nww", 128'(w_addr.size()), 128'(2));
        check("wfull_nwp", 128'(p_addr.size()), 128'(0));
        check("wfull_addr0", 128'(w_addr[0]), 128'(0));
        check("wfull_addr1", 128'(w_addr[1]), 128'(1));
        check("wfull_data0", 128'(w_data[0]), 128'(e0));
        check("wfull_data1", 128'(w_data[1]), 128'(e1));
        check("wfull_e0_const", 128'(e0), 128'(72'h010203040506070809));

        // Partial final group, pack_len=3 over 7 words
        start(1'b1, 300, 306, 3);
        wait_done("wpart_done_seen");
        e0 = 72'hA1A2A3_000000_000000;
        e1 = 72'hA4A5A6_000000_000000;
        e2 = 72'hA70000_000000_000000;
        check("wpart_nww", 128'(w_addr.size()), 128'(3));
        check("wpart_data0", 128'(w_data[0]), 128'(e0));
        check("wpart_data1", 128'(w_data[1]), 128'(e1));
        check("wpart_data2", 128'(w_data[2]), 128'(e2));
        check("wpart_addr2", 128'(w_addr[2]), 128'(2));
        check("wpart_cyc0", 128'(w_cyc[0] - go_cyc), 128'(4));
        check("wpart_cyc2", 128'(w_cyc[2] - go_cyc), 128'(8));
        check("wpart_donecyc", 128'(done_cyc[0] - go_cyc), 128'(9));

        // pack_len=0 clamps to one lane
        start(1'b1, 400, 401, 0);
        wait_done("wclamp0_done_seen");
        check("wclamp0_nww", 128'(w_addr.size()), 128'(2));
        check("wclamp0_data0", 128'(w_data[0]), 128'(72'h11 << 64));
        check("wclamp0_data1", 128'(w_data[1]), 128'(72'h22 << 64));
        check("wclamp0_addr1", 128'(w_addr[1]), 128'(1));

        // pack_len=12 clamps to K=9
        start(1'b1, 200, 208, 12);
        wait_done("wclampk_done_seen");
        check("wclampk_nww", 128'(w_addr.size()), 128'(1));
        check("wclampk_data0", 128'(w_data[0]), 128'(72'h010203040506070809));

        // Empty range
        start(1'b1, 10, 9, 3);
        wait_done("empty_done_seen");
        check("empty_nrd", 128'(rd_addr.size()), 128'(0));
        check("empty_nwr", 128'(p_addr.size() + w_addr.size()), 128'(0));
        check("empty_donecyc", 128'(done_cyc[0] - go_cyc), 128'(1));

        // go while busy is ignored
        start(1'b0, 100, 103, 0);
        @(negedge clk);
        mode = 1'b1; first_addr = 13'd0; last_addr = 13'd50; pack_len = 4'd2;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done("gobusy_done_seen");
        check_pixel4("gobusy");

        // Reset mid-load aborts, then a fresh load starts from index 0
        start(1'b0, 500, 509, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_ram_re", 128'(ram_re), 128'(0));
        check("mrst_we_p", 128'(we_p), 128'(0));
        check("mrst_busy", 128'(busy), 128'(0));
        check("mrst_done", 128'(done), 128'(0));
        check("mrst_ram_addr", 128'(ram_addr), 128'(0));
        check("mrst_addrp", 128'(addrp), 128'(0));
        check("mrst_dp", 128'(dp), 128'(0));
        check("mrst_addrw", 128'(addrw), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        np = p_addr.size();
        repeat (20) @(negedge clk);
        check("mrst_no_writes", 128'(p_addr.size()), 128'(np));
        check("mrst_no_done", 128'(done_cyc.size()), 128'(0));
        start(1'b0, 100, 103, 0);
        wait_done("reload_done_seen");
        check_pixel4("reload");

        check("we_exclusive", 128'(both_hi), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
